// File: rtl/loop_index_sequencer.sv
// Clocked loop-index sequencer: walks an index from start_index by STEP, one
// step per clock, until the next value would reach or pass LIMIT.
module loop_index_sequencer #(
  parameter int IDX_W = 4,
  parameter int LIMIT = 10,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] start_index,
  input  logic             abort,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [IDX_W:0]   final_index,
  output logic             reached_limit,
  output logic [IDX_W:0]   iter_count
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one loop iteration per cycle, index valid
  // DONE  | one-cycle completion pulse, accepts a new start
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // LIMIT may equal 2**IDX_W, so compares are done one bit wider than index.
  localparam logic [IDX_W:0] LIM = (IDX_W+1)'(LIMIT);
  localparam logic [IDX_W:0] STP = (IDX_W+1)'(STEP);

  state_t           state, state_n;
  logic [IDX_W-1:0] index_n;
  logic [IDX_W:0]   final_n, iter_n, nxt, start_ext;
  logic             reached_n, aborted_n;

  assign nxt       = {1'b0, index} + STP;
  assign start_ext = {1'b0, start_index};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      index         <= '0;
      final_index   <= '0;
      reached_limit <= 1'b0;
      iter_count    <= '0;
      aborted       <= 1'b0;
    end else begin
      state         <= state_n;
      index         <= index_n;
      final_index   <= final_n;
      reached_limit <= reached_n;
      iter_count    <= iter_n;
      aborted       <= aborted_n;
    end
  end

  always_comb begin
    state_n   = state;
    index_n   = index;
    final_n   = final_index;
    reached_n = reached_limit;
    iter_n    = iter_count;
    aborted_n = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (start) begin
          iter_n = '0;
          if (start_ext < LIM) begin
            state_n = RUN;
            index_n = start_index;
          end else begin
            state_n   = DONE;
            final_n   = start_ext;
            reached_n = (start_ext == LIM);
          end
        end
      end
      RUN: begin
        iter_n = iter_count + 1'b1;
        if (abort) begin
          state_n   = IDLE;
          aborted_n = 1'b1;
        end else if (nxt < LIM) begin
          index_n = nxt[IDX_W-1:0];
        end else begin
          state_n   = DONE;
          final_n   = nxt;
          reached_n = (nxt == LIM);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy        = (state == RUN);
  assign index_valid = (state == RUN);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_loop_index_sequencer.sv
// Directed bench for loop_index_sequencer: default, STEP=3 and LIMIT=16 builds.
module tb_loop_index_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [3:0] start_index = '0;
  logic       abort = 1'b0;

  logic [3:0] index0, index1, index2;
  logic       valid0, valid1, valid2, busy0, busy1, busy2;
  logic       done0, done1, done2, abt0, abt1, abt2;
  logic [4:0] fin0, fin1, fin2, iter0, iter1, iter2;
  logic       reach0, reach1, reach2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  loop_index_sequencer #(.IDX_W(4), .LIMIT(10), .STEP(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .start_index(start_index), .abort(abort),
    .index(index0), .index_valid(valid0), .busy(busy0), .done(done0), .aborted(abt0),
    .final_index(fin0), .reached_limit(reach0), .iter_count(iter0));

  loop_index_sequencer #(.IDX_W(4), .LIMIT(10), .STEP(3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .start_index(start_index), .abort(abort),
    .index(index1), .index_valid(valid1), .busy(busy1), .done(done1), .aborted(abt1),
    .final_index(fin1), .reached_limit(reach1), .iter_count(iter1));

  loop_index_sequencer #(.IDX_W(4), .LIMIT(16), .STEP(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .start_index(start_index), .abort(abort),
    .index(index2), .index_valid(valid2), .busy(busy2), .done(done2), .aborted(abt2),
    .final_index(fin2), .reached_limit(reach2), .iter_count(iter2));

  // Advance one clock and sample shortly after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({index0, valid0, busy0, done0, abt0, fin0, reach0, iter0} !== '0) begin
      errors++;
      $display("FAIL reset_u0 got idx=%0d v=%b b=%b d=%b a=%b fin=%0d r=%b it=%0d want all 0",
               index0, valid0, busy0, done0, abt0, fin0, reach0, iter0);
    end
    rst_n = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({busy0, done0, busy1, done1, busy2, done2} !== 6'b0) begin
      errors++;
      $display("FAIL reset_idle got b0=%b d0=%b b1=%b d1=%b b2=%b d2=%b want 0",
               busy0, done0, busy1, done1, busy2, done2);
    end
  endtask

  task automatic test_basic();
    start_index = 4'd7;
    start0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      start0 = 1'b0;
      checks++;
      if (index0 !== 4'(7 + i) || valid0 !== 1'b1 || busy0 !== 1'b1 || done0 !== 1'b0 ||
          iter0 !== 5'(i)) begin
        errors++;
        $display("FAIL basic_run%0d got idx=%0d v=%b b=%b d=%b it=%0d want idx=%0d v=1 b=1 d=0 it=%0d",
                 i, index0, valid0, busy0, done0, iter0, 7 + i, i);
      end
    end
    cyc();
    checks++;
    if (done0 !== 1'b1 || valid0 !== 1'b0 || fin0 !== 5'd10 || reach0 !== 1'b1 || iter0 !== 5'd3) begin
      errors++;
      $display("FAIL basic_done got d=%b v=%b fin=%0d r=%b it=%0d want d=1 v=0 fin=10 r=1 it=3",
               done0, valid0, fin0, reach0, iter0);
    end
    cyc();
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0 || fin0 !== 5'd10 || reach0 !== 1'b1) begin
      errors++;
      $display("FAIL basic_after got d=%b b=%b fin=%0d r=%b want d=0 b=0 fin=10 r=1",
               done0, busy0, fin0, reach0);
    end
  endtask

  task automatic test_zero_iter();
    start_index = 4'd12;
    start0 = 1'b1;
    cyc();
    start0 = 1'b0;
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || fin0 !== 5'd12 || reach0 !== 1'b0 || iter0 !== 5'd0) begin
      errors++;
      $display("FAIL zero12 got d=%b b=%b fin=%0d r=%b it=%0d want d=1 b=0 fin=12 r=0 it=0",
               done0, busy0, fin0, reach0, iter0);
    end
    cyc();
    start_index = 4'd10;
    start0 = 1'b1;
    cyc();
    start0 = 1'b0;
    checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || fin0 !== 5'd10 || reach0 !== 1'b1 || iter0 !== 5'd0) begin
      errors++;
      $display("FAIL zero10 got d=%b b=%b fin=%0d r=%b it=%0d want d=1 b=0 fin=10 r=1 it=0",
               done0, busy0, fin0, reach0, iter0);
    end
    cyc();
    checks++;
    if (done0 !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_len got d=%b want 0", done0);
    end
  endtask

  task automatic test_step3();
    start_index = 4'd2;
    start1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      start1 = 1'b0;
      checks++;
      if (index1 !== 4'(2 + 3 * i) || valid1 !== 1'b1) begin
        errors++;
        $display("FAIL step3_run%0d got idx=%0d v=%b want idx=%0d v=1", i, index1, valid1, 2 + 3 * i);
      end
    end
    cyc();
    checks++;
    if (done1 !== 1'b1 || fin1 !== 5'd11 || reach1 !== 1'b0 || iter1 !== 5'd3) begin
      errors++;
      $display("FAIL step3_done got d=%b fin=%0d r=%b it=%0d want d=1 fin=11 r=0 it=3",
               done1, fin1, reach1, iter1);
    end
    cyc();
  endtask

  task automatic test_no_wrap();
    start_index = 4'd14;
    start2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      start2 = 1'b0;
      checks++;
      if (index2 !== 4'(14 + i) || valid2 !== 1'b1) begin
        errors++;
        $display("FAIL nowrap_run%0d got idx=%0d v=%b want idx=%0d v=1", i, index2, valid2, 14 + i);
      end
    end
    cyc();
    checks++;
    if (done2 !== 1'b1 || fin2 !== 5'd16 || reach2 !== 1'b1 || iter2 !== 5'd2) begin
      errors++;
      $display("FAIL nowrap_done got d=%b fin=%0d r=%b it=%0d want d=1 fin=16 r=1 it=2",
               done2, fin2, reach2, iter2);
    end
    cyc();
  endtask

  task automatic test_abort();
    // u0 holds final_index=10, reached_limit=1 from the previous run.
    start_index = 4'd0;
    start0 = 1'b1;
    cyc();
    start0 = 1'b0;
    cyc();
    start_index = 4'd5;
    start0 = 1'b1;          // ignored while running
    cyc();
    start0 = 1'b0;
    checks++;
    if (index0 !== 4'd2 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL abort_ignore_start got idx=%0d b=%b want idx=2 b=1", index0, busy0);
    end
    cyc();
    abort = 1'b1;
    checks++;
    if (index0 !== 4'd3 || iter0 !== 5'd3) begin
      errors++;
      $display("FAIL abort_pre got idx=%0d it=%0d want idx=3 it=3", index0, iter0);
    end
    cyc();
    abort = 1'b0;
    checks++;
    if (abt0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0 || fin0 !== 5'd10 ||
        reach0 !== 1'b1 || iter0 !== 5'd4) begin
      errors++;
      $display("FAIL abort_pulse got a=%b d=%b b=%b fin=%0d r=%b it=%0d want a=1 d=0 b=0 fin=10 r=1 it=4",
               abt0, done0, busy0, fin0, reach0, iter0);
    end
    cyc();
    checks++;
    if (abt0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_after got a=%b d=%b b=%b want 0 0 0", abt0, done0, busy0);
    end
    abort = 1'b1;           // ignored in IDLE
    cyc();
    abort = 1'b0;
    checks++;
    if (abt0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got a=%b want 0", abt0);
    end
  endtask

  task automatic test_reset_midrun();
    start_index = 4'd0;
    start0 = 1'b1;
    cyc();
    start0 = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (index0 !== 4'd5 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre got idx=%0d b=%b want idx=5 b=1", index0, busy0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({index0, valid0, busy0, done0, abt0, fin0, reach0, iter0} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got idx=%0d v=%b b=%b d=%b a=%b fin=%0d r=%b it=%0d want all 0",
               index0, valid0, busy0, done0, abt0, fin0, reach0, iter0);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release got d=%b b=%b want 0 0", done0, busy0);
    end
  endtask

  task automatic test_back_to_back();
    start_index = 4'd9;
    start0 = 1'b1;
    abort = 1'b1;           // start wins over abort in IDLE
    cyc();
    start0 = 1'b0;
    abort = 1'b0;
    checks++;
    if (index0 !== 4'd9 || valid0 !== 1'b1 || iter0 !== 5'd0) begin
      errors++;
      $display("FAIL b2b_first got idx=%0d v=%b it=%0d want idx=9 v=1 it=0", index0, valid0, iter0);
    end
    start_index = 4'd8;
    start0 = 1'b1;          // lands in the DONE cycle
    cyc();
    checks++;
    if (done0 !== 1'b1 || fin0 !== 5'd10 || reach0 !== 1'b1 || iter0 !== 5'd1) begin
      errors++;
      $display("FAIL b2b_done1 got d=%b fin=%0d r=%b it=%0d want d=1 fin=10 r=1 it=1",
               done0, fin0, reach0, iter0);
    end
    cyc();
    start0 = 1'b0;
    checks++;
    if (index0 !== 4'd8 || busy0 !== 1'b1 || done0 !== 1'b0 || iter0 !== 5'd0) begin
      errors++;
      $display("FAIL b2b_restart got idx=%0d b=%b d=%b it=%0d want idx=8 b=1 d=0 it=0",
               index0, busy0, done0, iter0);
    end
    cyc();
    cyc();
    checks++;
    if (done0 !== 1'b1 || fin0 !== 5'd10 || iter0 !== 5'd2) begin
      errors++;
      $display("FAIL b2b_done2 got d=%b fin=%0d it=%0d want d=1 fin=10 it=2", done0, fin0, iter0);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_iter();
    test_step3();
    test_no_wrap();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_index_sequencer.md
Name: loop_index_sequencer

Overview:
Clocked, parametrised loop-index sequencer. It replaces a combinational while-style scan with a cycle-per-iteration walk from a start index up to a limit. Each accepted start request steps an index by STEP once per clock until the index would reach or pass LIMIT. The block then reports the exit index, whether LIMIT was hit exactly, and the iteration count. Controller/report interface blocks use it to drive index/done status.

Parameters:
IDX_W, 4, width of start_index and index
LIMIT, 10, exclusive upper bound of the loop; legal range 1..2**IDX_W
STEP, 1, per-iteration increment; legal range 1..2**IDX_W-1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a loop run; sampled in IDLE or DONE
start_index  input  IDX_W  initial index; sampled with start
abort  input  1  terminate a run in progress
index  output  IDX_W  current loop index; valid while index_valid=1
index_valid  output  1  high in every RUN cycle
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE (normal completion only)
aborted  output  1  one-cycle pulse on the cycle after an accepted abort
final_index  output  IDX_W+1  exit index; held until the next start is accepted
reached_limit  output  1  final_index == LIMIT; held with final_index
iter_count  output  IDX_W+1  number of RUN cycles in the last or current run

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - index, final_index and iter_count are 0.
  - index_valid, busy, done, aborted and reached_limit are 0.
- States: IDLE, RUN, DONE.
- All arithmetic is done in IDX_W+1 bits: nxt = {1'b0,index} + STEP. There is no wrap-around; the index is never truncated.
- IDLE or DONE with start=1:
  - If start_index < LIMIT: go to RUN next cycle with index=start_index and iter_count=0.
  - Otherwise: go to DONE next cycle with final_index=start_index, reached_limit=(start_index==LIMIT) and iter_count=0. This is a zero-iteration run.
- RUN, every cycle:
  - iter_count increments by 1.
  - If nxt < LIMIT: index<=nxt and stay in RUN.
  - Otherwise: go to DONE with final_index<=nxt and reached_limit<=(nxt==LIMIT).
- RUN with abort=1 (abort has priority over completion in the same cycle):
  - Next state is IDLE and aborted pulses for one cycle.
  - done does not pulse; final_index and reached_limit keep their previous values.
  - iter_count includes the aborting cycle.
- DONE lasts exactly one cycle (done=1). With no start it returns to IDLE. A start in DONE is accepted as in IDLE, so runs can be back-to-back.
- start in RUN is ignored. abort in IDLE or DONE is ignored.
- start and abort together in IDLE: start is accepted.
- Latency:
  - First index_valid one cycle after start.
  - done pulse N+1 cycles after start for a run of N iterations; 1 cycle when N=0.
- Reset asserted mid-run returns all outputs to their reset values immediately. After reset release, no done is produced until a new start.

Test Plan:
- Default params, start=1 with start_index=7 -> index 7,8,9 with index_valid on cycles 1-3; done on cycle 4; final_index=10, reached_limit=1, iter_count=3.
- start_index=12 -> no RUN; done on cycle 1; final_index=12, reached_limit=0, iter_count=0. start_index=10 -> done on cycle 1, reached_limit=1.
- STEP=3, start_index=2 -> index 2,5,8; final_index=11, reached_limit=0, iter_count=3.
- IDX_W=4, LIMIT=16, start_index=14 -> index 14,15; final_index=16 (no wrap), reached_limit=1.
- start_index=0, abort on the 4th RUN cycle (index=3) -> aborted pulse, no done, return to IDLE; final_index unchanged; start during the run ignored.
- rst_n low during RUN at index=5 -> outputs immediately 0. After release, start with start_index=9 -> single iteration, final_index=10. Also check a back-to-back start in the DONE cycle.
